// File: rtl/vga_pkg.sv
// Shared types and constants for the vga_* overlay generators: the line table
// entry layout, colour/RGB widths and the line table size limit.
package vga_pkg;

  localparam int LINE_COORD_W = 10;
  localparam int LINE_DASH_W  = 4;
  localparam int COLOUR_W     = 5;
  localparam int RGB_W        = 8;
  localparam int MAX_LINES    = 16;

  typedef struct packed {
    logic                    en;
    logic [LINE_COORD_W-1:0] x0;
    logic [LINE_COORD_W-1:0] x1;
    logic [LINE_COORD_W-1:0] y;
    logic [COLOUR_W-1:0]     colour;
    logic [LINE_DASH_W-1:0]  on;
    logic [LINE_DASH_W-1:0]  off;
  } line_cfg_t;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int addr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_colour.sv
// Palette lookup shared by the overlay generators. Index 0 is transparent
// (c_mask=0); every other index maps to a fixed opaque RGB colour.
module vga_colour
  import vga_pkg::*;
(
  input  logic [COLOUR_W-1:0] colour_idx,
  output logic [RGB_W-1:0]    r,
  output logic [RGB_W-1:0]    g,
  output logic [RGB_W-1:0]    b,
  output logic                c_mask
);

  always_comb begin
    c_mask = (colour_idx != '0);
    r      = {colour_idx, 3'b000};
    g      = {~colour_idx, 3'b111};
    b      = {colour_idx[2:0], colour_idx};
  end

endmodule

// File: rtl/vga_hline_dash.sv
// Run-length dash generator for one line table entry: phase counter that
// restarts at x0 on the entry's row and advances only over the drawn span.
module vga_hline_dash
  import vga_pkg::*;
#(
  parameter int DASH_W = LINE_DASH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              frame_start,
  input  logic              at_x0,
  input  logic              in_span,
  input  logic [DASH_W-1:0] on,
  input  logic [DASH_W-1:0] off,
  output logic              dash_on
);

  localparam logic [DASH_W:0] ONE = {{DASH_W{1'b0}}, 1'b1};

  logic [DASH_W:0] phase_reg;
  logic [DASH_W:0] phase_used;
  logic [DASH_W:0] period_last;

  assign phase_used  = at_x0 ? '0 : phase_reg;
  // One extra bit keeps on+off exact for the largest run lengths.
  assign period_last = {1'b0, on} + {1'b0, off} - ONE;
  assign dash_on     = (off == '0) || (phase_used < {1'b0, on});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
    end else if (frame_start) begin
      phase_reg <= '0;
    end else if (pix_en && in_span) begin
      phase_reg <= (phase_used == period_last) ? '0 : phase_used + ONE;
    end
  end

endmodule

// File: rtl/vga_hline_gen.sv
// Multi-entry horizontal line / graticule overlay with per-entry dash pattern,
// lowest-index priority and a two-stage registered pixel output.
// Define VGA_HLINE_SHADOW_EN for a shadow table loaded on frame_start.
module vga_hline_gen
  import vga_pkg::*;
#(
  parameter  int NUM_LINES = 4,
  parameter  int COORD_W   = LINE_COORD_W,
  parameter  int DASH_W    = LINE_DASH_W,
  localparam int AW        = addr_w(NUM_LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic               cfg_en,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_x1,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [4:0]         cfg_colour,
  input  logic [DASH_W-1:0]  cfg_on,
  input  logic [DASH_W-1:0]  cfg_off,
  output logic               out_valid,
  output logic [7:0]         out_r,
  output logic [7:0]         out_g,
  output logic [7:0]         out_b,
  output logic [AW-1:0]      out_line
);

  if (COORD_W != LINE_COORD_W || DASH_W != LINE_DASH_W ||
      NUM_LINES < 1 || NUM_LINES > MAX_LINES) begin : g_bad_param
    $error("vga_hline_gen: parameters do not match vga_pkg line_cfg_t");
  end

  line_cfg_t act_tbl [NUM_LINES];
  line_cfg_t wr_cfg;

  always_comb begin
    wr_cfg        = '0;
    wr_cfg.en     = cfg_en;
    wr_cfg.x0     = cfg_x0;
    wr_cfg.x1     = cfg_x1;
    wr_cfg.y      = cfg_y;
    wr_cfg.colour = cfg_colour;
    wr_cfg.on     = cfg_on;
    wr_cfg.off    = cfg_off;
  end

`ifdef VGA_HLINE_SHADOW_EN
  line_cfg_t shd_tbl [NUM_LINES];

  // A write landing on frame_start is forwarded straight into the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        shd_tbl[i] <= '0;
        act_tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (cfg_we && cfg_addr == AW'(i)) shd_tbl[i] <= wr_cfg;
        if (frame_start)
          act_tbl[i] <= (cfg_we && cfg_addr == AW'(i)) ? wr_cfg : shd_tbl[i];
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) act_tbl[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++)
        if (cfg_we && cfg_addr == AW'(i)) act_tbl[i] <= wr_cfg;
    end
  end
`endif

  logic [NUM_LINES-1:0] hit;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic row_hit;
    logic in_span;
    logic at_x0;
    logic dash_on;

    assign row_hit = (pix_y == act_tbl[g].y);
    assign in_span = row_hit && (pix_x >= act_tbl[g].x0) && (pix_x <= act_tbl[g].x1);
    assign at_x0   = row_hit && (pix_x == act_tbl[g].x0);

    vga_hline_dash #(.DASH_W(DASH_W)) u_dash (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .frame_start (frame_start),
      .at_x0       (at_x0),
      .in_span     (in_span),
      .on          (act_tbl[g].on),
      .off         (act_tbl[g].off),
      .dash_on     (dash_on)
    );

    assign hit[g] = pix_en && act_tbl[g].en && in_span && dash_on;
  end

  logic [AW-1:0]       win_line;
  logic [COLOUR_W-1:0] win_colour;

  always_comb begin
    win_line   = '0;
    win_colour = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_line   = AW'(i);
        win_colour = act_tbl[i].colour;
      end
    end
  end

  logic                s1_valid;
  logic                s1_hit;
  logic [AW-1:0]       s1_line;
  logic [COLOUR_W-1:0] s1_colour;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_line   <= '0;
      s1_colour <= '0;
    end else begin
      s1_valid  <= pix_en;
      s1_hit    <= |hit;
      s1_line   <= win_line;
      s1_colour <= win_colour;
    end
  end

  logic [RGB_W-1:0] pal_r;
  logic [RGB_W-1:0] pal_g;
  logic [RGB_W-1:0] pal_b;
  logic             pal_mask;
  logic             draw;

  vga_colour u_colour (
    .colour_idx (s1_colour),
    .r          (pal_r),
    .g          (pal_g),
    .b          (pal_b),
    .c_mask     (pal_mask)
  );

  // A transparent winner blanks the pixel; lower entries are not consulted.
  assign draw = s1_valid && s1_hit && pal_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_line  <= '0;
    end else begin
      out_valid <= draw;
      out_r     <= draw ? pal_r : '0;
      out_g     <= draw ? pal_g : '0;
      out_b     <= draw ? pal_b : '0;
      out_line  <= draw ? s1_line : '0;
    end
  end

endmodule

// File: doc/vga_hline_gen.md
# vga_hline_gen

Multi-line horizontal line and graticule renderer for the scope display pipeline. It holds a programmable table of NUM_LINES horizontal segments, each with its own colour and run-length dash pattern. On each pixel it picks the highest-priority segment that draws there and emits a registered RGB pixel with a valid flag; there are no tri-state outputs. It sits beside the other vga_* overlay generators, is fed by pix_x/pix_y, and drives the overlay mixer.

## Interface
- NUM_LINES, 4: number of line table entries (1..16).
- COORD_W, 10: width of pixel coordinates.
- DASH_W, 4: width of dash on/off run lengths.
- clk  in  1  pixel clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- pix_en  in  1  current pixel is in the active area; qualifies pix_x/pix_y.
- pix_x  in  COORD_W  current x.
- pix_y  in  COORD_W  current y.
- frame_start  in  1  one-cycle pulse before the first pixel of a frame.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(NUM_LINES) (min 1)  entry index.
- cfg_en, cfg_x0, cfg_x1, cfg_y, cfg_colour, cfg_on, cfg_off  in  1, COORD_W, COORD_W, COORD_W, 5, DASH_W, DASH_W  entry fields.
- out_valid  out  1  out_r/g/b carry an overlay pixel.
- out_r, out_g, out_b  out  8 each  pixel colour.
- out_line  out  $clog2(NUM_LINES)  index of the winning entry.

## Operation
- Entry draws at (x,y) when all of the following hold: en=1, pix_y==y, x0<=pix_x<=x1, dash_on. If x0>x1, the entry never draws.
- Dash: off==0 gives a solid line. If on==0 and off!=0, the entry never draws.
- Per-entry phase counter, DASH_W+1 bits, updated only on pix_en cycles.
  - At pix_x==x0 on row y, phase_used=0; elsewhere phase_used=phase_reg.
  - dash_on = phase_used < on.
  - Inside the span, phase_reg <= (phase_used == on+off-1) ? 0 : phase_used+1. The sum is computed at DASH_W+1 bits, with no overflow.
  - Outside the span, phase_reg holds its value.
  - frame_start clears all phase counters.
- Priority: the lowest index among drawing entries wins.
- The winning colour goes through vga_colour. If c_mask=0 (transparent), out_valid=0, and lower-priority entries are NOT consulted.
- Writes: cfg_we with cfg_addr<NUM_LINES updates every field of that entry. An out-of-range address is ignored.

## Timing
- Stage 1 registers per-entry hits, the winner index and colour index. Stage 2 registers the vga_colour output. Latency is 2 clk from pix_x/pix_y/pix_en to outputs, with a pipeline advance every clk.
- out_valid = pix_en delayed 2 cycles AND hit AND c_mask.
- When out_valid=0, out_r/g/b=0 and out_line=0.
- Reset (asynchronous, any time, including mid-line):
  - outputs 0;
  - all entries en=0 and all fields 0;
  - phase counters 0;
  - pipeline valids 0.
- The first valid output appears 2 cycles after the first pix_en following reset release.
- A cfg write affects the hit test in the cycle after cfg_we (without shadowing, see Configuration).
- Simultaneous frame_start and pix_en: phase clear takes priority.

## Configuration
- VGA_HLINE_SHADOW_EN defined:
  - writes land in a shadow table;
  - the active table is loaded from shadow on frame_start;
  - a write coinciding with frame_start is included in the copy;
  - a tear-free update happens once per frame.
- Undefined: a single table that writes modify directly, so mid-frame writes may tear the current frame.

## Structure
- Package vga_pkg holds:
  - the line_cfg_t struct (en, x0, x1, y, colour, on, off), parameterised via COORD_W/DASH_W constants;
  - the colour index width (5) and RGB width (8);
  - the NUM_LINES maximum (16).
- Sub-module vga_hline_dash: one per entry, generated. It contains the phase counter and dash_on logic, taking pix_en, frame_start, at_x0, in_span, on and off.
- Reuses the existing vga_colour for palette lookup (one instance, stage 2).

## Test plan
- Solid line: entry0 = {en, x0=10, x1=20, y=5, colour opaque, off=0}. Scan row 5 → out_valid=1 for x=10..20 (11 pixels), 2 cycles late; 0 elsewhere and on other rows.
- Dash: entry0 with on=3, off=2, x0=100, x1=111. Draws x=100-102, 105-107, 110-111. The pattern restarts on the next row at x0.
- Priority/transparency: entry0 transparent and entry1 opaque, same row and span → out_valid=0. Entry0 disabled → out_valid=1 with out_line=1.
- Boundaries: x0=x1=0 draws one pixel. x0=50, x1=40 draws nothing. x1=1023 with COORD_W=10 draws through the edge. on=0, off=1 draws nothing.
- Shadow (macro defined): rewrite entry0 y=5→7 mid-frame → the rest of the frame still draws y=5. After frame_start, it draws y=7. Without the macro, it switches immediately.
- Reset mid-line at x=15 of the solid line → outputs 0 asynchronously and table cleared. Nothing draws after release until rewritten.
